// File: rtl/filter2d_cfg_if.sv
// filter2d_cfg_if: pixel stream and host config port bundle for filter2d_cfg.
interface filter2d_cfg_if #(parameter int DW = 8, parameter int CW = 8);
    logic          i_strb;
    logic [DW-1:0] i_data;
    logic          o_strb;
    logic [DW-1:0] o_data;
    logic          h_write;
    logic [3:0]    h_idx;
    logic [CW-1:0] h_data;
    modport slave (input i_strb, i_data, h_write, h_idx, h_data, output o_strb, o_data);
    modport master (output i_strb, i_data, h_write, h_idx, h_data, input o_strb, o_data);
endinterface

// File: rtl/filter2d_cfg.sv
// filter2d_cfg: 3x3 streaming convolution with runtime kernel/shift/border mode and frame-synchronous config.
module filter2d_cfg #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int SW = 4
) (
    input logic clk,
    input logic reset_n,
    filter2d_cfg_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = $clog2(IMG_W + 2);
    localparam int PRW = DW + CW + 1;
    localparam int SUMW = DW + CW + 5;
    localparam logic [PW-1:0] PRIME = PW'(IMG_W + 1);
    localparam logic [XW-1:0] XL = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YL = YW'(IMG_H - 1);

    logic signed [CW-1:0] r_k_sh [9];
    logic signed [CW-1:0] r_k_in [9];
    logic signed [CW-1:0] r_k_out [9];
    logic signed [CW-1:0] w_k_nx [9];
    logic [SW-1:0] r_sh_sh, r_sh_in, r_sh_out, r_sh1, w_sh_nx;
    logic r_md_sh, r_md_in, r_md_out, w_md_nx;
    logic [XW-1:0] r_icol, r_ocol;
    logic [YW-1:0] r_irow, r_orow;
    logic [PW-1:0] r_prime;
    logic [DW-1:0] r_lb0 [IMG_W];
    logic [DW-1:0] r_lb1 [IMG_W];
    logic [DW-1:0] r_win [3][3];
    logic [3:0] r_bd;
    logic r_v0, r_v1;
    logic signed [PRW-1:0] r_p [9];
    logic [DW-1:0] w_tap [9];
    logic signed [SUMW-1:0] w_sum, w_shd;
    logic [DW-1:0] w_clamp;
    logic w_in0, w_fire, w_out0;

    assign w_in0 = bus.i_strb && r_irow == '0 && r_icol == '0;
    assign w_fire = bus.i_strb && r_prime == PRIME;
    assign w_out0 = w_fire && r_orow == '0 && r_ocol == '0;

    // a write landing on the (0,0) strobe must reach the active copy, so latch from the next-state values
    always_comb begin
        for (int j = 0; j < 9; j++)
            w_k_nx[j] = (bus.h_write && bus.h_idx == 4'(j)) ? bus.h_data : r_k_sh[j];
        w_sh_nx = (bus.h_write && bus.h_idx == 4'd9) ? bus.h_data[SW-1:0] : r_sh_sh;
        w_md_nx = (bus.h_write && bus.h_idx == 4'd10) ? bus.h_data[0] : r_md_sh;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k_sh <= '{default: '0};
            r_k_in <= '{default: '0};
            r_k_out <= '{default: '0};
            {r_sh_sh, r_sh_in, r_sh_out, r_sh1} <= '0;
            {r_md_sh, r_md_in, r_md_out} <= '0;
            {r_icol, r_ocol, r_irow, r_orow, r_prime, r_bd} <= '0;
            {r_v0, r_v1} <= '0;
            bus.o_strb <= 1'b0;
            bus.o_data <= '0;
        end else begin
            r_k_sh <= w_k_nx;
            r_sh_sh <= w_sh_nx;
            r_md_sh <= w_md_nx;
            if (w_in0) begin
                r_k_in <= w_k_nx;
                r_sh_in <= w_sh_nx;
                r_md_in <= w_md_nx;
            end
            // outputs still draining from the previous frame keep its config until output (0,0) is formed
            if (w_out0) begin
                r_k_out <= r_k_in;
                r_sh_out <= r_sh_in;
                r_md_out <= r_md_in;
            end
            if (bus.i_strb) begin
                r_icol <= (r_icol == XL) ? '0 : r_icol + 1'b1;
                if (r_icol == XL) r_irow <= (r_irow == YL) ? '0 : r_irow + 1'b1;
                if (r_prime != PRIME) r_prime <= r_prime + 1'b1;
            end
            if (w_fire) begin
                r_ocol <= (r_ocol == XL) ? '0 : r_ocol + 1'b1;
                if (r_ocol == XL) r_orow <= (r_orow == YL) ? '0 : r_orow + 1'b1;
                r_bd <= {r_orow == '0, r_orow == YL, r_ocol == '0, r_ocol == XL};
            end
            r_v0 <= w_fire;
            r_v1 <= r_v0;
            r_sh1 <= r_sh_out;
            bus.o_strb <= r_v1;
            if (r_v1) bus.o_data <= w_clamp;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_strb) begin
            r_lb0[r_icol] <= bus.i_data;
            r_lb1[r_icol] <= r_lb0[r_icol];
            for (int y = 0; y < 3; y++) begin
                r_win[y][0] <= r_win[y][1];
                r_win[y][1] <= r_win[y][2];
            end
            r_win[0][2] <= r_lb1[r_icol];
            r_win[1][2] <= r_lb0[r_icol];
            r_win[2][2] <= bus.i_data;
        end
        for (int j = 0; j < 9; j++)
            r_p[j] <= PRW'($signed({1'b0, w_tap[j]})) * PRW'(r_k_out[j]);
    end

    // out-of-image taps either vanish or fold onto the centre row/column
    for (genvar y = 0; y < 3; y++) begin : g_r
        for (genvar x = 0; x < 3; x++) begin : g_c
            logic w_off_r, w_off_c;
            logic [1:0] w_ry, w_cx;
            assign w_off_r = (y == 0 && r_bd[3]) || (y == 2 && r_bd[2]);
            assign w_off_c = (x == 0 && r_bd[1]) || (x == 2 && r_bd[0]);
            assign w_ry = w_off_r ? 2'd1 : 2'(y);
            assign w_cx = w_off_c ? 2'd1 : 2'(x);
            assign w_tap[y*3+x] = ((w_off_r || w_off_c) && !r_md_out) ? '0 : r_win[w_ry][w_cx];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < 9; j++)
            w_sum = w_sum + SUMW'(r_p[j]);
        w_shd = w_sum >>> r_sh1;
        w_clamp = w_shd[SUMW-1] ? '0 : (|w_shd[SUMW-2:DW]) ? '1 : w_shd[DW-1:0];
    end
endmodule

// File: tb/tb_filter2d_cfg.sv
// tb_filter2d_cfg: randomized self-checking bench for filter2d_cfg against a frame-level convolution model.
`timescale 1ns/1ps
module tb_filter2d_cfg;
    localparam int W = 16, H = 16, N = W * H;
    typedef struct { int at; int idx; int d; } wr_t;

    logic clk = 0, reset_n = 0;
    filter2d_cfg_if #(.DW(8), .CW(8)) bus ();
    filter2d_cfg #(.IMG_W(W), .IMG_H(H), .DW(8), .CW(8), .SW(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0, sp = 1;
    int icyc [$];
    int ocyc [$];
    logic [7:0] q_out [$];
    logic [7:0] exp_q [$];
    wr_t wr_q [$];
    int m_k [9];
    int m_sh;
    bit m_md;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.o_strb === 1'b1) begin
        q_out.push_back(bus.o_data);
        ocyc.push_back(cyc);
    end

    // plain 2-D convolution over a whole stored frame
    function automatic logic [7:0] ref_px(input logic [7:0] im [N], input int k [9], input int sh, input bit md, input int r, input int c);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                int rr = r + dy;
                int cc = c + dx;
                if (!md && (rr < 0 || rr >= H || cc < 0 || cc >= W)) continue;
                rr = rr < 0 ? 0 : rr >= H ? H - 1 : rr;
                cc = cc < 0 ? 0 : cc >= W ? W - 1 : cc;
                s += int'(im[rr * W + cc]) * k[(dy + 1) * 3 + dx + 1];
            end
        s = s >>> sh;
        return s < 0 ? 8'd0 : s > 255 ? 8'd255 : 8'(s);
    endfunction

    task automatic clear_state();
        m_k = '{default: 0};
        m_sh = 0;
        m_md = 0;
        icyc.delete(); ocyc.delete(); q_out.delete(); exp_q.delete(); wr_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        clear_state();
    endtask

    task automatic apply_wr(input int idx, input int d);
        bus.h_write = 1; bus.h_idx = 4'(idx); bus.h_data = 8'(d);
        if (idx < 9) m_k[idx] = int'($signed(8'(d)));
        else if (idx == 9) m_sh = d & 15;
        else if (idx == 10) m_md = d[0];
    endtask

    task automatic hwrite(input int idx, input int d);
        apply_wr(idx, d);
        @(posedge clk); #1;
        bus.h_write = 0;
    endtask

    task automatic load_cfg(input int k [9], input int sh, input int md);
        for (int j = 0; j < 9; j++) hwrite(j, k[j]);
        hwrite(9, sh);
        hwrite(10, md);
    endtask

    task automatic rand_load();
        int k [9];
        foreach (k[j]) k[j] = int'($urandom_range(15)) - 8;
        load_cfg(k, int'($urandom_range(4)), int'($urandom_range(1)));
    endtask

    task automatic strobe(input logic [7:0] d);
        if (wr_q.size() > 0 && wr_q[0].at == icyc.size()) begin
            apply_wr(wr_q[0].idx, wr_q[0].d);
            wr_q.delete(0);
        end
        bus.i_strb = 1; bus.i_data = d; icyc.push_back(cyc);
        @(posedge clk); #1;
        bus.i_strb = 0; bus.h_write = 0; bus.i_data = 0;
        repeat (sp - 1) begin @(posedge clk); #1; end
    endtask

    task automatic feed_frame(input bit rnd, input int val);
        logic [7:0] im [N];
        int k [9];
        int sh;
        bit md;
        for (int n = 0; n < N; n++) begin
            im[n] = rnd ? 8'($urandom) : 8'(val);
            strobe(im[n]);
            if (n == 0) begin k = m_k; sh = m_sh; md = m_md; end
        end
        for (int n = 0; n < N; n++) exp_q.push_back(ref_px(im, k, sh, md, n / W, n % W));
    endtask

    task automatic feed_tail(input int cnt);
        repeat (cnt) strobe(8'($urandom));
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.o_strb !== 1'b0) begin miscompares++; $display("FAIL reset o_strb got %b want 0", bus.o_strb); end
        vectors++;
        if (bus.o_data !== 8'd0) begin miscompares++; $display("FAIL reset o_data got %0h want 0", bus.o_data); end
        @(posedge clk); #1 reset_n = 1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (bus.o_strb !== 1'b0) begin miscompares++; $display("FAIL idle o_strb got %b want 0", bus.o_strb); end
        end
        @(posedge clk); #1;
        clear_state();
    endtask

    task automatic test_identity();
        do_reset();
        sp = 1;
        load_cfg('{0, 0, 0, 0, 1, 0, 0, 0, 0}, 0, 0);
        feed_frame(1, 0);
        feed_frame(1, 0);
        feed_tail(W + 1);
        vectors++;
        if (q_out.size() != 2 * N) begin miscompares++; $display("FAIL identity count got %0d want %0d", q_out.size(), 2 * N); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] got = i < q_out.size() ? q_out[i] : 8'hxx;
            vectors++;
            if (got !== exp_q[i]) begin miscompares++; $display("FAIL identity px %0d got %0h want %0h", i, got, exp_q[i]); end
        end
        for (int i = 0; i < q_out.size(); i++) begin
            int want = i + W + 1 < icyc.size() ? icyc[i + W + 1] + 3 : -1;
            vectors++;
            if (ocyc[i] != want) begin miscompares++; $display("FAIL identity latency out %0d got cycle %0d want %0d", i, ocyc[i], want); end
        end
    endtask

    task automatic test_border();
        for (int md = 0; md < 2; md++) begin
            do_reset();
            load_cfg('{1, 1, 1, 1, 1, 1, 1, 1, 1}, 3, md);
            feed_frame(0, 100);
            feed_tail(W + 1);
            vectors++;
            if (q_out.size() != N) begin miscompares++; $display("FAIL border%0d count got %0d want %0d", md, q_out.size(), N); end
            for (int i = 0; i < exp_q.size(); i++) begin
                logic [7:0] got = i < q_out.size() ? q_out[i] : 8'hxx;
                vectors++;
                if (got !== exp_q[i]) begin miscompares++; $display("FAIL border%0d px %0d got %0d want %0d", md, i, got, exp_q[i]); end
            end
            vectors++;
            if (q_out.size() > 0 && q_out[0] !== (md ? 8'd112 : 8'd50)) begin
                miscompares++; $display("FAIL border%0d corner got %0d want %0d", md, q_out[0], md ? 112 : 50);
            end
        end
    endtask

    task automatic test_saturate();
        for (int t = 0; t < 2; t++) begin
            logic [7:0] want = t ? 8'd0 : 8'd255;
            do_reset();
            if (t == 0) load_cfg('{1, 1, 1, 1, 1, 1, 1, 1, 1}, 0, 0);
            else load_cfg('{0, 0, 0, 0, -1, 0, 0, 0, 0}, 0, 0);
            feed_frame(0, 200);
            feed_tail(W + 1);
            vectors++;
            if (q_out.size() != N) begin miscompares++; $display("FAIL clamp%0d count got %0d want %0d", t, q_out.size(), N); end
            for (int i = 0; i < q_out.size(); i++) begin
                vectors++;
                if (q_out[i] !== want) begin miscompares++; $display("FAIL clamp%0d px %0d got %0d want %0d", t, i, q_out[i], want); end
            end
        end
    endtask

    task automatic test_midframe_write();
        do_reset();
        load_cfg('{0, 0, 0, 0, 1, 0, 0, 0, 0}, 0, 0);
        wr_q.push_back('{100, 4, 2});
        feed_frame(1, 0);
        feed_frame(1, 0);
        feed_tail(W + 1);
        vectors++;
        if (q_out.size() != 2 * N) begin miscompares++; $display("FAIL midwrite count got %0d want %0d", q_out.size(), 2 * N); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] got = i < q_out.size() ? q_out[i] : 8'hxx;
            vectors++;
            if (got !== exp_q[i]) begin miscompares++; $display("FAIL midwrite px %0d got %0h want %0h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_load();
        for (int j = 0; j < 9; j++) wr_q.push_back('{50 + j, j, int'($urandom_range(15)) - 8});
        wr_q.push_back('{60, 9, int'($urandom_range(3))});
        wr_q.push_back('{61, 10, int'($urandom_range(1))});
        wr_q.push_back('{N, 4, int'($urandom_range(15)) - 8});
        feed_frame(1, 0);
        feed_frame(1, 0);
        feed_tail(W + 1);
        vectors++;
        if (q_out.size() != 2 * N) begin miscompares++; $display("FAIL random count got %0d want %0d", q_out.size(), 2 * N); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] got = i < q_out.size() ? q_out[i] : 8'hxx;
            vectors++;
            if (got !== exp_q[i]) begin miscompares++; $display("FAIL random px %0d got %0h want %0h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_restart();
        int gaps [2] = '{1, 17};
        foreach (gaps[g]) begin
            do_reset();
            sp = gaps[g];
            rand_load();
            feed_tail(100);
            reset_n = 0;
            repeat (2) begin
                @(negedge clk);
                vectors++;
                if (bus.o_strb !== 1'b0 || bus.o_data !== 8'd0) begin
                    miscompares++; $display("FAIL restart%0d in reset got strb %b data %0h want 0 0", sp, bus.o_strb, bus.o_data);
                end
                @(posedge clk); #1;
            end
            reset_n = 1;
            clear_state();
            rand_load();
            feed_frame(1, 0);
            feed_tail(W + 1);
            vectors++;
            if (q_out.size() != N) begin miscompares++; $display("FAIL restart%0d count got %0d want %0d", sp, q_out.size(), N); end
            for (int i = 0; i < exp_q.size(); i++) begin
                logic [7:0] got = i < q_out.size() ? q_out[i] : 8'hxx;
                vectors++;
                if (got !== exp_q[i]) begin miscompares++; $display("FAIL restart%0d px %0d got %0h want %0h", sp, i, got, exp_q[i]); end
            end
            for (int i = 0; i < q_out.size(); i++) begin
                int want = i + W + 1 < icyc.size() ? icyc[i + W + 1] + 3 : -1;
                vectors++;
                if (ocyc[i] != want) begin miscompares++; $display("FAIL restart%0d latency out %0d got %0d want %0d", sp, i, ocyc[i], want); end
            end
        end
        sp = 1;
    endtask

    initial begin
        bus.i_strb = 0; bus.i_data = 0; bus.h_write = 0; bus.h_idx = 0; bus.h_data = 0;
        clear_state();
        test_reset();
        test_identity();
        test_border();
        test_saturate();
        test_midframe_write();
        test_random();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
